input_buffer: RTL and testbench

- Feed-side counterpart of the output buffer. External host writes operand words into a 16-entry register file by address.
- A streaming engine then reads a contiguous, wrapping address range and presents it word-by-word to the systolic array's input through a valid/ready handshake.
- Sits between the external interface and the array's operand input, mirroring the output buffer at the result end.

---
 rtl/input_buffer.sv | 96 +++++++++
 tb/tb_input_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// Operand feed buffer: host writes a 16-entry register file, a stream engine replays a wrapping range to the array.
// Latency 1 cycle from start to arr_valid; the presented word and arr_valid hold while arr_ready is low.
module input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] arr_data,
  output logic              arr_valid,
  input  logic              arr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_L = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_hs;

  assign w_hs      = r_valid & arr_ready;
  assign arr_data  = r_data;
  assign arr_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Fetch and host write share one block; the fetch sees the pre-write value on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (ext_wr_en) r_mem[ext_wr_addr] <= ext_data;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (length != '0) begin
              r_ptr   <= start_addr + ONE_A;
              r_rem   <= length;
              r_data  <= r_mem[start_addr];
              r_valid <= 1'b1;
              r_state <= S_STREAM;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (r_rem == ONE_L) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_data <= r_mem[r_ptr];
              r_ptr  <= r_ptr + ONE_A;
              r_rem  <= r_rem - ONE_L;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: one task per scenario, inline comparisons, one summary line.
module tb_input_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              ext_wr_en;
  logic [ADDR_W-1:0] ext_wr_addr;
  logic [DATA_W-1:0] ext_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] arr_data;
  logic              arr_valid;
  logic              arr_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  input_buffer #(.DATA_W(DATA_W), .DEPTH(16), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_wr_en  (ext_wr_en),
    .ext_wr_addr(ext_wr_addr),
    .ext_data   (ext_data),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .arr_data   (arr_data),
    .arr_valid  (arr_valid),
    .arr_ready  (arr_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ext_wr_en   = 1'b1;
    ext_wr_addr = a;
    ext_data    = d;
    tick();
    ext_wr_en   = 1'b0;
  endtask

  task automatic kick(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] got [$];
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (arr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || arr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h, want 0 0 0 0", arr_valid, busy, done, arr_data);
    end
    arr_ready = 1'b1;
    kick(4'd0, 5'd4);
    for (int i = 0; i < 6; i++) begin
      if (arr_valid && arr_ready) got.push_back(arr_data);
      tick();
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL reset_stream_count: got %0d words, want 4", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_stream_data[%0d]: got %h, want 0", i, got[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] exp_d [3];
    exp_d[0] = 32'h102; exp_d[1] = 32'h103; exp_d[2] = 32'h104;
    for (int i = 0; i < 16; i++) write_word(4'(i), 32'h100 + 32'(i));
    arr_ready = 1'b1;
    kick(4'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (arr_valid !== 1'b1 || arr_data !== exp_d[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_word[%0d]: valid=%b data=%h busy=%b done=%b, want 1 %h 1 0",
                 i, arr_valid, arr_data, busy, done, exp_d[i]);
      end
      tick();
    end
    checks++;
    if (arr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: valid=%b done=%b busy=%b, want 0 1 1", arr_valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || arr_data !== 32'h104) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b data=%h, want 0 0 00000104", done, busy, arr_data);
    end
  endtask

  task automatic test_backpressure_wrap();
    logic              pat [7];
    logic [DATA_W-1:0] exp_d [4];
    logic [DATA_W-1:0] prev_d;
    logic              prev_stall;
    int                hs;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    exp_d[0] = 32'h10E; exp_d[1] = 32'h10F; exp_d[2] = 32'h100; exp_d[3] = 32'h101;
    hs = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    kick(4'd14, 5'd4);
    for (int j = 0; j < 7; j++) begin
      arr_ready = pat[j];
      if (prev_stall) begin
        checks++;
        if (arr_valid !== 1'b1 || arr_data !== prev_d) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%b data=%h, want 1 %h", j, arr_valid, arr_data, prev_d);
        end
      end
      if (arr_valid && arr_ready) begin
        checks++;
        if (hs < 4 && arr_data !== exp_d[hs]) begin
          errors++;
          $display("FAIL bp_data[%0d]: got %h, want %h", hs, arr_data, exp_d[hs]);
        end
        hs++;
      end
      prev_stall = arr_valid && !arr_ready;
      prev_d = arr_data;
      tick();
    end
    checks++;
    if (hs != 4 || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_count: handshakes=%0d done=%b, want 4 1", hs, done);
    end
    arr_ready = 1'b1;
    tick();
  endtask

  task automatic test_len0();
    kick(4'd3, 5'd0);
    checks++;
    if (arr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL len0_done: valid=%b done=%b busy=%b, want 0 1 1", arr_valid, done, busy);
    end
    tick();
    checks++;
    if (arr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle: valid=%b done=%b busy=%b, want 0 0 0", arr_valid, done, busy);
    end
  endtask

  task automatic test_len16();
    logic [ADDR_W-1:0] a;
    arr_ready = 1'b1;
    kick(4'd5, 5'd16);
    for (int i = 0; i < 16; i++) begin
      a = 4'(5 + i);
      checks++;
      if (arr_valid !== 1'b1 || arr_data !== (32'h100 + 32'(a))) begin
        errors++;
        $display("FAIL len16_word[%0d]: valid=%b data=%h, want 1 %h", i, arr_valid, arr_data, 32'h100 + 32'(a));
      end
      tick();
    end
    checks++;
    if (arr_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL len16_done: valid=%b done=%b, want 0 1", arr_valid, done);
    end
    tick();
  endtask

  task automatic test_start_busy();
    int hs;
    hs = 0;
    arr_ready = 1'b1;
    kick(4'd0, 5'd2);
    start = 1'b1;
    start_addr = 4'd8;
    length = 5'd3;
    for (int i = 0; i < 2; i++) begin
      if (arr_valid && arr_ready) begin
        checks++;
        if (arr_data !== 32'h100 + 32'(i)) begin
          errors++;
          $display("FAIL busy_word[%0d]: got %h, want %h", i, arr_data, 32'h100 + 32'(i));
        end
        hs++;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || arr_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: done=%b valid=%b, want 1 0", done, arr_valid);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (arr_valid) hs++;
    end
    checks++;
    if (hs != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: words=%0d busy=%b, want 2 0", hs, busy);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] exp_d [4];
    arr_ready = 1'b1;
    kick(4'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arr_valid !== 1'b1 || arr_data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL coll_first[%0d]: valid=%b data=%h, want 1 %h", i, arr_valid, arr_data, 32'h100 + 32'(i));
      end
      // the edge ending word 2 is the one that fetches entry 3
      if (i == 2) begin
        ext_wr_en = 1'b1; ext_wr_addr = 4'd3; ext_data = 32'hDEAD;
      end
      tick();
      ext_wr_en = 1'b0;
    end
    tick();
    exp_d[0] = 32'h100; exp_d[1] = 32'h101; exp_d[2] = 32'h102; exp_d[3] = 32'hDEAD;
    kick(4'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arr_valid !== 1'b1 || arr_data !== exp_d[i]) begin
        errors++;
        $display("FAIL coll_repeat[%0d]: valid=%b data=%h, want 1 %h", i, arr_valid, arr_data, exp_d[i]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_async_reset();
    int seen_done;
    int words;
    seen_done = 0;
    words = 0;
    arr_ready = 1'b1;
    kick(4'd0, 5'd8);
    tick();
    checks++;
    if (arr_valid !== 1'b1 || arr_data !== 32'h101) begin
      errors++;
      $display("FAIL arst_second: valid=%b data=%h, want 1 00000101", arr_valid, arr_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (arr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: valid=%b busy=%b done=%b, want 0 0 0", arr_valid, busy, done);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done++;
      tick();
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL arst_no_done: done pulses=%0d, want 0", seen_done);
    end
    kick(4'd0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      if (arr_valid) begin
        words++;
        checks++;
        if (arr_data !== 32'h0) begin
          errors++;
          $display("FAIL arst_cleared[%0d]: got %h, want 0", i, arr_data);
        end
      end
      tick();
    end
    checks++;
    if (words != 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL arst_readback: words=%0d done=%b, want 16 1", words, done);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    ext_wr_en = 1'b0;
    ext_wr_addr = '0;
    ext_data = '0;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    arr_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure_wrap();
    test_len0();
    test_len16();
    test_start_busy();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
